// File: rtl/integral_image_gen_if.sv
// Pixel-in / integral-out stream bundle for integral_image_gen.
//   in_valid/in_pixel/in_ready      : raster-order pixel stream into the block
//   out_valid/out_data/out_addr/out_ready : integral word stream out of the block
// master = stream source/sink side (testbench or upstream/downstream logic),
// slave  = the integral image generator itself.
interface integral_image_gen_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [31:0]      out_addr;
  logic             out_ready;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/integral_image_gen.sv
// Streaming integral image (summed-area table) generator.
// Consumes pixels in raster order and emits ii(x,y) = sum of all pixels
// above and left of (x,y) inclusive, one word per accepted pixel, with the
// flat address y*width+x alongside.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : frame start pulse, honoured only in IDLE
//   img_width/height   : frame size, latched on start (width clamped to MAX_W)
//   busy               : frame in progress (RUN or DONE)
//   frame_done         : one-cycle pulse in the DONE state
//   overflow           : sticky per-frame saturation flag
//   bus (slave)        : pixel input and integral output handshakes
//
// Build option: define INTEGRAL_SAT_EN to saturate at 2^OUT_W-1 and raise
// overflow; otherwise arithmetic wraps and overflow stays 0.
module integral_image_gen #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 32,
  parameter int MAX_W = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] img_width,
  input  logic [15:0] img_height,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  integral_image_gen_if.slave bus
);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
`ifdef INTEGRAL_SAT_EN
  // Two spare bits so a pixel plus a saturated term can never wrap silently.
  localparam int SUM_W = ((PIX_W > OUT_W) ? PIX_W : OUT_W) + 2;
`else
  localparam int SUM_W = OUT_W;
`endif
  localparam logic [OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [15:0]      width_q, height_q, x_q, y_q;
  logic [OUT_W-1:0] rowsum_q;
  logic [31:0]      addr_q;
  logic             exhausted_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [31:0]      out_addr_q;
  logic             overflow_q;

  // Previous row of integral values, indexed by column.
  logic [OUT_W-1:0] prev [MAX_W];

  logic             accept, out_xfer, last_pix, row_end;
  logic [SUM_W-1:0] rs_sum, ii_sum;
  logic [OUT_W-1:0] rs_next, ii_next, prev_rd;
  logic             sat_hit;

  assign bus.in_ready = (state == RUN) && (!out_valid_q || bus.out_ready) && !exhausted_q;
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign row_end  = (x_q == width_q - 16'd1);
  assign last_pix = row_end && (y_q == height_q - 16'd1);
  // Row 0 ignores whatever the buffer holds, so it never needs clearing.
  assign prev_rd  = (y_q == 16'd0) ? '0 : prev[x_q[AW-1:0]];

  always_comb begin
    rs_sum  = SUM_W'(bus.in_pixel) + ((x_q == 16'd0) ? '0 : SUM_W'(rowsum_q));
`ifdef INTEGRAL_SAT_EN
    rs_next = (rs_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : rs_sum[OUT_W-1:0];
    ii_sum  = SUM_W'(rs_next) + SUM_W'(prev_rd);
    ii_next = (ii_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : ii_sum[OUT_W-1:0];
    // A saturated row sum already pins ii at max even when prev is 0.
    sat_hit = (rs_sum > SUM_W'(SAT_MAX)) || (ii_sum > SUM_W'(SAT_MAX));
`else
    rs_next = rs_sum;
    ii_sum  = rs_sum + prev_rd;
    ii_next = ii_sum;
    sat_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rowsum_q    <= '0;
      addr_q      <= '0;
      exhausted_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          width_q     <= (img_width > 16'(MAX_W)) ? 16'(MAX_W) : img_width;
          height_q    <= img_height;
          x_q         <= '0;
          y_q         <= '0;
          rowsum_q    <= '0;
          addr_q      <= '0;
          exhausted_q <= 1'b0;
          overflow_q  <= 1'b0;
          state       <= (img_width == 16'd0 || img_height == 16'd0) ? DONE : RUN;
        end
        RUN: begin
          if (out_xfer) out_valid_q <= 1'b0;
          if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ii_next;
            out_addr_q  <= addr_q;
            addr_q      <= addr_q + 32'd1;
            rowsum_q    <= rs_next;
            if (sat_hit) overflow_q <= 1'b1;
            if (row_end) begin
              x_q <= '0;
              y_q <= y_q + 16'd1;
            end else begin
              x_q <= x_q + 16'd1;
            end
            if (last_pix) exhausted_q <= 1'b1;
          end
          // Accept is blocked once exhausted, so this never races a new word.
          if (out_xfer && exhausted_q) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) prev[x_q[AW-1:0]] <= ii_next;
  end

  assign busy          = (state != IDLE);
  assign frame_done    = (state == DONE);
  assign overflow      = overflow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
endmodule

// File: tb/tb_integral_image_gen.sv
module tb_integral_image_gen;
  localparam int PIX_W = 8;
  localparam int OUT_W = 12;
  localparam int MAX_W = 16;
  localparam longint MAXV = (longint'(1) << OUT_W) - 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] img_width, img_height;
  logic        busy, frame_done, overflow;

  integral_image_gen_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

  integral_image_gen #(.PIX_W(PIX_W), .OUT_W(OUT_W), .MAX_W(MAX_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_width(img_width), .img_height(img_height),
    .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int     n_tests = 0, n_fail = 0;
  int     fd_cnt = 0, xfer_cnt = 0;
  longint exp_d[$];
  longint exp_a[$];
  bit     exp_ovf;
  int     pix[512];
  int     n, fr_w, fr_h;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hard_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Reference: every ii is the plain rectangle sum, then wrapped or clamped.
  task automatic prep(input int w, input int h, input int mode, input int cval);
    int we;
    longint s;
    we = (w > MAX_W) ? MAX_W : w;
    fr_w = w; fr_h = h; n = we * h;
    exp_d.delete(); exp_a.delete(); exp_ovf = 0;
    for (int i = 0; i < n; i++)
      pix[i] = (mode == 0) ? cval : (mode == 1) ? i + 1 : int'($urandom_range(255));
    for (int y = 0; y < h; y++)
      for (int x = 0; x < we; x++) begin
        s = 0;
        for (int j = 0; j <= y; j++)
          for (int i = 0; i <= x; i++) s += pix[j*we+i];
        if (s > MAXV) begin
`ifdef INTEGRAL_SAT_EN
          s = MAXV; exp_ovf = 1;
`else
          s = s % (MAXV + 1);
`endif
        end
        exp_d.push_back(s);
        exp_a.push_back(longint'(y*we + x));
      end
  endtask

  task automatic pin(input string nm, input int idx, input longint v);
    chk(nm, exp_d[idx], v);
  endtask

  // Output checker: every transferred word against the model, stall hold,
  // and no pixel taken while the output is stalled.
  initial begin
    bit prev_stall = 0;
    longint held_d = 0, held_a = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_stall) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, held_d);
          chk("hold_addr", bus.out_addr, held_a);
        end
        if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_d.size() == 0) hard_fail("unexpected_output");
          else begin
            chk("out_data", bus.out_data, exp_d.pop_front());
            chk("out_addr", bus.out_addr, exp_a.pop_front());
          end
          xfer_cnt++;
        end
        if (frame_done) fd_cnt++;
        prev_stall = bus.out_valid && !bus.out_ready;
        held_d = bus.out_data;
        held_a = bus.out_addr;
      end else prev_stall = 0;
    end
  end

  // ready_mode: 0 always ready, 1 random, 2 stall 5 cycles on the third word.
  task automatic run_frame(input bit rnd_valid, input int ready_mode,
                           input int abort_after, input bit mid_start);
    int p = 0, cyc = 0, fd0, x0, stall_left = 5, budget;
    bit ms_done = 0, aborted = 0;
    fd0 = fd_cnt; x0 = xfer_cnt; budget = n * 8 + 40;
    @(posedge clk); #1;
    start = 1; img_width = 16'(fr_w); img_height = 16'(fr_h);
    @(posedge clk); #1;
    start = 0;
    while (fd_cnt == fd0 && cyc < budget) begin
      if (abort_after != 0 && p == abort_after) begin
        reset = 1; bus.in_valid = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        exp_d.delete(); exp_a.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", fd_cnt, fd0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        aborted = 1;
        break;
      end
      bus.in_valid = (p < n) && (!rnd_valid || $urandom_range(3) != 0);
      bus.in_pixel = (p < n) ? PIX_W'(pix[p]) : '0;
      case (ready_mode)
        0: bus.out_ready = 1;
        1: bus.out_ready = ($urandom_range(2) != 0);
        default: begin
          bus.out_ready = !((xfer_cnt - x0) == 2 && bus.out_valid && stall_left > 0);
          if (!bus.out_ready) stall_left--;
        end
      endcase
      if (mid_start && !ms_done && p == n / 2) begin
        start = 1; img_width = 16'd1; img_height = 16'd1; ms_done = 1;
      end else start = 0;
      @(negedge clk);
      if (ready_mode == 2 && !bus.out_ready) begin
        chk("stall_data", bus.out_data, 6);
        chk("stall_addr", bus.out_addr, 2);
      end
      if (n == 0 && frame_done) begin
        chk("zero_dim_latency", cyc, 0);
        chk("zero_dim_busy", busy, 1);
      end
      if (bus.in_valid && bus.in_ready) p++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 0; start = 0;
    if (!aborted) begin
      if (fd_cnt == fd0) hard_fail("frame_timeout");
      @(negedge clk);
      chk("done_one_cycle", frame_done, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      chk("done_count", fd_cnt, fd0 + 1);
      chk("outputs_remaining", exp_d.size(), 0);
      chk("overflow", overflow, exp_ovf);
    end
  endtask

  initial begin
    reset = 1; start = 0; img_width = 0; img_height = 0;
    bus.in_valid = 0; bus.in_pixel = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    @(posedge clk); #1 reset = 0;

    // 3x3 all-ones
    prep(3, 3, 0, 1);
    pin("m33_0", 0, 1); pin("m33_2", 2, 3); pin("m33_4", 4, 4); pin("m33_8", 8, 9);
    run_frame(0, 0, 0, 0);

    // 4x2 ramp with a 5-cycle stall on the third word
    prep(4, 2, 1, 0);
    pin("m42_2", 2, 6); pin("m42_3", 3, 10); pin("m42_4", 4, 6); pin("m42_7", 7, 36);
    run_frame(0, 2, 0, 0);

    // 8x8 all-255: saturation or wrap at OUT_W=12
    prep(8, 8, 0, 255);
`ifdef INTEGRAL_SAT_EN
    pin("m88_last", 63, 4095);
`else
    pin("m88_last", 63, 4032);
`endif
    run_frame(0, 0, 0, 0);

    // zero width and zero height
    prep(0, 3, 0, 1);
    run_frame(0, 0, 0, 0);
    prep(5, 0, 0, 1);
    run_frame(0, 0, 0, 0);

    // abort 4x4 after 5 pixels, then a clean 2x2 all-2 frame
    prep(4, 4, 0, 200);
    run_frame(0, 0, 5, 0);
    prep(2, 2, 0, 2);
    pin("m22_1", 1, 4); pin("m22_2", 2, 4); pin("m22_3", 3, 8);
    run_frame(0, 0, 0, 0);

    // start pulsed mid-frame is ignored
    prep(5, 3, 2, 0);
    run_frame(1, 1, 0, 1);

    // width above MAX_W clamps
    prep(20, 1, 0, 1);
    pin("clamp_last", 15, 16);
    run_frame(0, 0, 0, 0);

    // random frames with random valid/ready
    for (int f = 0; f < 10; f++) begin
      prep(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)), 2, 0);
      run_frame(1, 1, 0, f[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/integral_image_gen.md
INTEGRAL_IMAGE_GEN -- requirements
Module: integral_image_gen

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter OUT_W, default 32, width of the integral value.
REQ-003 Parameter MAX_W, default 256, maximum image width in pixels; sets the line-buffer depth.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-007 img_width  input  16  frame width in pixels; latched on an accepted start.
REQ-008 img_height  input  16  frame height in pixels; latched on an accepted start.
REQ-009 in_valid  input  1  in_pixel is valid this cycle.
REQ-010 in_pixel  input  PIX_W  unsigned pixel, raster order.
REQ-011 in_ready  output  1  block accepts a pixel this cycle.
REQ-012 out_valid  output  1  out_data and out_addr are valid.
REQ-013 out_data  output  OUT_W  integral value ii(x,y).
REQ-014 out_addr  output  32  flat row-major address y*width+x.
REQ-015 out_ready  input  1  downstream accepts the output word.
REQ-016 busy  output  1  high in RUN and DONE.
REQ-017 frame_done  output  1  one-cycle pulse when the frame completes.
REQ-018 overflow  output  1  sticky per-frame overflow flag.

Function
REQ-019 FSM states: IDLE, RUN, DONE. IDLE->RUN on start with nonzero width and height. IDLE->DONE on start with either dimension zero. RUN->DONE when the last output word transfers. DONE->IDLE after exactly one cycle.
REQ-020 frame_done is high only during the DONE cycle. start is ignored in RUN and DONE.
REQ-021 A width greater than MAX_W is clamped to MAX_W when latched.
REQ-022 Computation: ii(x,y) = rowsum(x,y) + prev[x]. rowsum accumulates in_pixel (zero-extended) along the row and clears at x=0. prev[x] is 0 for y=0 and is otherwise the stored ii(x,y-1).
REQ-023 Line buffer prev[0..MAX_W-1]: prev[x] is read, then overwritten with the new ii(x,y), in the same accept cycle.
REQ-024 Input transfer occurs when in_valid && in_ready. in_ready = (state==RUN) && (!out_valid || out_ready) && pixels not exhausted.
REQ-025 Latency: each accepted pixel produces its output word registered on the next clock edge, so throughput is 1 pixel per cycle with no backpressure.
REQ-026 While out_valid && !out_ready, out_data and out_addr hold stable and no pixel is accepted.
REQ-027 x/y counters: x wraps to 0 at width-1 and y increments at that point. The last pixel is (width-1, height-1); no pixel is accepted after it.
REQ-028 overflow clears when a frame starts.

Reset
REQ-029 Reset forces IDLE; out_valid, in_ready, busy, frame_done and overflow go to 0; out_data and out_addr go to 0; counters and rowsum clear.
REQ-030 Reset mid-frame abandons the frame with no frame_done. Line-buffer contents are not cleared, because the y=0 rule masks them.

Configuration
REQ-031 Macro INTEGRAL_SAT_EN defined: ii saturates at 2^OUT_W-1, the saturated value is written to the line buffer, and overflow sets on any saturation.
REQ-032 Macro INTEGRAL_SAT_EN undefined: arithmetic wraps modulo 2^OUT_W and overflow is tied to 0.

Verification
REQ-033 3x3 frame of all-1 pixels, out_ready held 1 -> out_data 1,2,3,2,4,6,3,6,9 at out_addr 0..8, then one frame_done pulse.
REQ-034 4x2 frame of pixels 1..8 with out_ready low for 5 cycles after the third output -> out_data/out_addr held at 6/2, in_ready low throughout the stall, then the full sequence 1,3,6,10,6,14,24,36 with none lost.
REQ-035 OUT_W=12, 8x8 frame of all-255 pixels -> with INTEGRAL_SAT_EN the final out_data is 4095 and overflow=1; without it the final out_data is 16320 mod 4096 = 4032 and overflow=0.
REQ-036 start with img_width=0 -> DONE on the next cycle, one frame_done pulse, no out_valid.
REQ-037 Reset asserted after 5 pixels of a 4x4 frame, then a new 2x2 all-2 frame -> outputs 2,4,4,8; no stale line-buffer data appears and no frame_done for the aborted frame.
REQ-038 start pulsed in RUN -> ignored; the current frame completes unchanged.
